rc4_mem_sched: RTL

Top-level sequencer for the RC4 key-search datapath. It runs three engines in order for each candidate key: S-array init, key-schedule (KSA) and keystream/decrypt (PRGA). All three share the single-port 256x8 S memory, and this block grants that port to exactly one engine at a time. It steps the candidate key on a decrypt failure and stops when a key is found or the key space is exhausted.

---
 rtl/rc4_pkg.sv | 28 ++
 rtl/rc4_mem_mux.sv | 45 ++++
 rtl/rc4_mem_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search sequencer.
// RC4_WDOG_EN adds the watchdog error state.
package rc4_pkg;

  localparam int MEM_AW    = 8;
  localparam int MEM_DW    = 8;
  localparam int KEY_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_PRGA,
    ST_FOUND,
    ST_FAIL
`ifdef RC4_WDOG_EN
    , ST_WERR
`endif
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_INIT,
    GNT_KSA,
    GNT_PRGA
  } gnt_e;

endpackage

// File: rtl/rc4_mem_mux.sv
// Combinational 3:1 select of the single S-memory port.
// GNT_NONE parks the port: address/data zero, no write.
module rc4_mem_mux
  import rc4_pkg::*;
(
  input  gnt_e              gnt_i,
  input  logic [MEM_AW-1:0] init_addr_i,
  input  logic [MEM_DW-1:0] init_wdata_i,
  input  logic              init_wren_i,
  input  logic [MEM_AW-1:0] ksa_addr_i,
  input  logic [MEM_DW-1:0] ksa_wdata_i,
  input  logic              ksa_wren_i,
  input  logic [MEM_AW-1:0] prga_addr_i,
  input  logic [MEM_DW-1:0] prga_wdata_i,
  input  logic              prga_wren_i,
  output logic [MEM_AW-1:0] addr_o,
  output logic [MEM_DW-1:0] data_o,
  output logic              wren_o
);

  always_comb begin
    addr_o = '0;
    data_o = '0;
    wren_o = 1'b0;
    unique case (gnt_i)
      GNT_INIT: begin
        addr_o = init_addr_i;
        data_o = init_wdata_i;
        wren_o = init_wren_i;
      end
      GNT_KSA: begin
        addr_o = ksa_addr_i;
        data_o = ksa_wdata_i;
        wren_o = ksa_wren_i;
      end
      GNT_PRGA: begin
        addr_o = prga_addr_i;
        data_o = prga_wdata_i;
        wren_o = prga_wren_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_mem_sched.sv
// RC4 key-search sequencer: INIT -> KSA -> PRGA per key, S-port arbiter.
// RC4_WDOG_EN enables the per-phase watchdog (WERR state).
module rc4_mem_sched
  import rc4_pkg::*;
#(
  parameter int              KEY_W       = KEY_W_DEF,
  parameter logic [KEY_W-1:0] KEY_MAX    = KEY_W'(24'h3FFFFF),
  parameter int              WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [KEY_W-1:0]  key,
  output logic              init_start,
  input  logic              init_done,
  input  logic [MEM_AW-1:0] init_addr,
  input  logic [MEM_DW-1:0] init_wdata,
  input  logic              init_wren,
  output logic              ksa_start,
  input  logic              ksa_done,
  input  logic [MEM_AW-1:0] ksa_addr,
  input  logic [MEM_DW-1:0] ksa_wdata,
  input  logic              ksa_wren,
  output logic              prga_start,
  input  logic              prga_done,
  input  logic              prga_ok,
  input  logic [MEM_AW-1:0] prga_addr,
  input  logic [MEM_DW-1:0] prga_wdata,
  input  logic              prga_wren,
  output logic [MEM_AW-1:0] mem_address,
  output logic [MEM_DW-1:0] mem_data,
  output logic              wren,
  output logic              busy,
  output logic              found,
  output logic              fail,
  output logic              wdog_err
);

  state_e           state_q;
  logic [KEY_W-1:0] key_q;
  logic             init_start_q;
  logic             ksa_start_q;
  logic             prga_start_q;
  logic             wdog_hit;
  gnt_e             gnt;

`ifdef RC4_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES + 1);
  logic [WCW-1:0] wcnt_q;
  logic [WCW-1:0] wage;

  // Every phase entry carries its start pulse, so age restarts there.
  assign wage     = (init_start_q | ksa_start_q | prga_start_q) ? '0 : wcnt_q;
  assign wdog_hit = (wage == WCW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) wcnt_q <= '0;
    else          wcnt_q <= wage + 1'b1;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      init_start_q <= 1'b0;
      ksa_start_q  <= 1'b0;
      prga_start_q <= 1'b0;
    end else begin
      init_start_q <= 1'b0;
      ksa_start_q  <= 1'b0;
      prga_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_FOUND, ST_FAIL: if (start) begin
          key_q        <= '0;
          state_q      <= ST_INIT;
          init_start_q <= 1'b1;
        end
`ifdef RC4_WDOG_EN
        ST_WERR: if (start) begin
          key_q        <= '0;
          state_q      <= ST_INIT;
          init_start_q <= 1'b1;
        end
`endif
        ST_INIT: begin
          if (init_done) begin
            state_q     <= ST_KSA;
            ksa_start_q <= 1'b1;
          end
`ifdef RC4_WDOG_EN
          else if (wdog_hit) state_q <= ST_WERR;
`endif
        end
        ST_KSA: begin
          if (ksa_done) begin
            state_q      <= ST_PRGA;
            prga_start_q <= 1'b1;
          end
`ifdef RC4_WDOG_EN
          else if (wdog_hit) state_q <= ST_WERR;
`endif
        end
        ST_PRGA: begin
          if (prga_done) begin
            if (prga_ok) begin
              state_q <= ST_FOUND;
            end else if (key_q == KEY_MAX) begin
              state_q <= ST_FAIL;
            end else begin
              key_q        <= key_q + 1'b1;
              state_q      <= ST_INIT;
              init_start_q <= 1'b1;
            end
          end
`ifdef RC4_WDOG_EN
          else if (wdog_hit) state_q <= ST_WERR;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    gnt = GNT_NONE;
    unique case (state_q)
      ST_INIT: gnt = GNT_INIT;
      ST_KSA:  gnt = GNT_KSA;
      ST_PRGA: gnt = GNT_PRGA;
      default: gnt = GNT_NONE;
    endcase
  end

  rc4_mem_mux u_mux (
    .gnt_i        (gnt),
    .init_addr_i  (init_addr),
    .init_wdata_i (init_wdata),
    .init_wren_i  (init_wren),
    .ksa_addr_i   (ksa_addr),
    .ksa_wdata_i  (ksa_wdata),
    .ksa_wren_i   (ksa_wren),
    .prga_addr_i  (prga_addr),
    .prga_wdata_i (prga_wdata),
    .prga_wren_i  (prga_wren),
    .addr_o       (mem_address),
    .data_o       (mem_data),
    .wren_o       (wren)
  );

  assign key        = key_q;
  assign init_start = init_start_q;
  assign ksa_start  = ksa_start_q;
  assign prga_start = prga_start_q;
  assign busy       = (gnt != GNT_NONE);
  assign found      = (state_q == ST_FOUND);
  assign fail       = (state_q == ST_FAIL);
`ifdef RC4_WDOG_EN
  assign wdog_err   = (state_q == ST_WERR) | (wdog_hit & 1'b0);
`else
  assign wdog_err   = wdog_hit | (WDOG_CYCLES < 0);
`endif

endmodule
